// File: rtl/mips_cpu_bus_arbiter_if.sv
// Bundles the two CPU requester ports and the shared Avalon-MM master port.
// Pure wiring, no latency of its own.
// waitrequest from the slave stalls the arbiter; requesters hold req until ack.
interface mips_cpu_bus_arbiter_if;
    // instruction fetch requester
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;

    // data load/store requester
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        busy;

    // Avalon-MM master port
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    // arbiter side: owns the Avalon master and the acknowledges
    modport master (
        input  i_req, i_addr,
        output i_ack, i_rdata, i_err,
        input  d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        output d_ack, d_rdata, d_err,
        output busy,
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    // environment side: requesters plus the Avalon slave
    modport slave (
        output i_req, i_addr,
        input  i_ack, i_rdata, i_err,
        output d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        input  d_ack, d_rdata, d_err,
        input  busy,
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// Arbitrates fetch and data requests onto one Avalon-MM master with sub-word store/load formatting.
// Latency: strobe one cycle after the request, ack one cycle after the accepting edge (2 cycles zero-wait).
// Backpressure: bus fields held constant while waitrequest=1; each wait cycle adds one cycle of latency.
module mips_cpu_bus_arbiter (
    input  logic                          clk,
    input  logic                          rst,
    mips_cpu_bus_arbiter_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;     // 0 = instruction port, 1 = data port
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic        lat_we;
    logic [1:0]  lat_off;

    logic        i_elig;
    logic        d_elig;
    logic        pick_i;
    logic        pick_d;
    logic        i_mis;
    logic        d_mis;
    logic [3:0]  d_be;
    logic [31:0] d_wd;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;

    // Eligibility and round-robin choice; a port whose ack is high this cycle is ignored
    always_comb begin
        i_elig = bus.i_req && !bus.i_ack;
        d_elig = bus.d_req && !bus.d_ack;
        pick_d = d_elig && (!i_elig || !last_grant);
        pick_i = i_elig && !pick_d;
    end

    // Alignment check: fetches need word alignment, data alignment depends on access size
    always_comb begin
        i_mis = (bus.i_addr[1:0] != 2'b00);
        case (bus.d_size)
            2'd0:    d_mis = 1'b0;
            2'd1:    d_mis = bus.d_addr[0];
            default: d_mis = (bus.d_addr[1:0] != 2'b00);
        endcase
    end

    // Store formatting: lane enables plus store data replicated across every lane
    always_comb begin
        case (bus.d_size)
            2'd0: begin
                d_be = 4'b0001 << bus.d_addr[1:0];
                d_wd = {4{bus.d_wdata[7:0]}};
            end
            2'd1: begin
                d_be = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                d_wd = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                d_be = 4'b1111;
                d_wd = bus.d_wdata;
            end
        endcase
    end

    // Load formatting from the fields latched at grant: pick the lane, then extend
    always_comb begin
        byte_v = bus.readdata[{lat_off, 3'b000} +: 8];
        half_v = lat_off[1] ? bus.readdata[31:16] : bus.readdata[15:0];
        case (lat_size)
            2'd0:    load_val = {{24{lat_signed & byte_v[7]}}, byte_v};
            2'd1:    load_val = {{16{lat_signed & half_v[15]}}, half_v};
            default: load_val = bus.readdata;
        endcase
        if (lat_we) begin
            load_val = 32'd0;
        end
    end

    // Control FSM with registered bus strobes, acknowledges and result data
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b0;
            lat_size       <= 2'd0;
            lat_signed     <= 1'b0;
            lat_we         <= 1'b0;
            lat_off        <= 2'd0;
            bus.i_ack      <= 1'b0;
            bus.i_err      <= 1'b0;
            bus.i_rdata    <= 32'd0;
            bus.d_ack      <= 1'b0;
            bus.d_err      <= 1'b0;
            bus.d_rdata    <= 32'd0;
            bus.busy       <= 1'b0;
            bus.address    <= 32'd0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.writedata  <= 32'd0;
            bus.byteenable <= 4'd0;
        end else begin
            // acknowledges and their data are single-cycle pulses
            bus.i_ack   <= 1'b0;
            bus.i_err   <= 1'b0;
            bus.i_rdata <= 32'd0;
            bus.d_ack   <= 1'b0;
            bus.d_err   <= 1'b0;
            bus.d_rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        last_grant <= 1'b1;
                        if (d_mis) begin
                            bus.d_ack <= 1'b1;
                            bus.d_err <= 1'b1;
                        end else begin
                            bus.address    <= {bus.d_addr[31:2], 2'b00};
                            bus.read       <= !bus.d_we;
                            bus.write      <= bus.d_we;
                            bus.byteenable <= d_be;
                            bus.writedata  <= d_wd;
                            bus.busy       <= 1'b1;
                            lat_size       <= bus.d_size;
                            lat_signed     <= bus.d_signed;
                            lat_we         <= bus.d_we;
                            lat_off        <= bus.d_addr[1:0];
                            state          <= BUS_D;
                        end
                    end else if (pick_i) begin
                        last_grant <= 1'b0;
                        if (i_mis) begin
                            bus.i_ack <= 1'b1;
                            bus.i_err <= 1'b1;
                        end else begin
                            bus.address    <= {bus.i_addr[31:2], 2'b00};
                            bus.read       <= 1'b1;
                            bus.write      <= 1'b0;
                            bus.byteenable <= 4'b1111;
                            bus.writedata  <= 32'd0;
                            bus.busy       <= 1'b1;
                            state          <= BUS_I;
                        end
                    end
                end
                BUS_I: begin
                    if (!bus.waitrequest) begin
                        bus.read    <= 1'b0;
                        bus.write   <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.i_ack   <= 1'b1;
                        bus.i_rdata <= bus.readdata;
                        state       <= IDLE;
                    end
                end
                BUS_D: begin
                    if (!bus.waitrequest) begin
                        bus.read    <= 1'b0;
                        bus.write   <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.d_ack   <= 1'b1;
                        bus.d_rdata <= load_val;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: directed accesses with hand-computed expectations.
// Expected bus transfers and acknowledges are queued at issue time and popped by monitors.
// The slave model inserts a configurable number of wait states per transfer.
module tb_mips_cpu_bus_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter_if bus();

    mips_cpu_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } bus_exp_t;

    ack_exp_t    iq[$];
    ack_exp_t    dq[$];
    bus_exp_t    bq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wcnt = 0;          // wait states the slave inserts per transfer
    logic [31:0] slave_rdata = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle=%0d", name, cyc);
    endtask

    // Slave model and bus monitor: insert wait states, check every strobe cycle against the oldest expected transfer
    always @(negedge clk) begin
        logic strobe;
        logic prev_strobe;
        int   wleft;
        strobe = (bus.read === 1'b1) || (bus.write === 1'b1);
        if (strobe && !prev_strobe) wleft = wcnt;
        if (strobe && wleft > 0) begin
            bus.waitrequest = 1'b1;
            wleft--;
        end else begin
            bus.waitrequest = 1'b0;
        end
        bus.readdata = slave_rdata;
        if (bus.read === 1'b1 && bus.write === 1'b1) flag("read_and_write");
        if (strobe) begin
            if (bq.size() == 0) begin
                flag("unexpected_strobe");
            end else begin
                if (!prev_strobe) chk("strobe_cycle", 32'(cyc), 32'(bq[0].cyc));
                chk("address", bus.address, bq[0].addr);
                chk("read", 32'(bus.read), 32'(!bq[0].we));
                chk("write", 32'(bus.write), 32'(bq[0].we));
                chk("byteenable", 32'(bus.byteenable), 32'(bq[0].be));
                chk("busy", 32'(bus.busy), 32'd1);
                if (bq[0].we) chk("writedata", bus.writedata, bq[0].wdata);
                if (!bus.waitrequest) void'(bq.pop_front());
            end
        end
        prev_strobe = strobe;
    end

    // Ack monitor: each acknowledge must match the oldest expectation for its port
    always @(negedge clk) begin
        ack_exp_t e;
        if (bus.i_ack === 1'b1 && bus.d_ack === 1'b1) flag("both_acks");
        if (bus.i_ack === 1'b1) begin
            if (iq.size() == 0) begin
                flag("unexpected_i_ack");
            end else begin
                e = iq.pop_front();
                chk("i_ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("i_rdata", bus.i_rdata, e.rdata);
                chk("i_err", 32'(bus.i_err), 32'(e.err));
            end
        end
        if (bus.d_ack === 1'b1) begin
            if (dq.size() == 0) begin
                flag("unexpected_d_ack");
            end else begin
                e = dq.pop_front();
                chk("d_ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("d_rdata", bus.d_rdata, e.rdata);
                chk("d_err", 32'(bus.d_err), 32'(e.err));
            end
        end
    end

    // Fetch requester: n word fetches from addr0 upward, req held until ack, dropped in the ack cycle
    task automatic run_i(input logic [31:0] addr0, input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            bus.i_addr = addr0 + 32'(4 * k);
            bus.i_req  = 1'b1;
            do begin
                @(posedge clk); #1;
                t++;
            end while (bus.i_ack !== 1'b1 && t < 40);
            if (bus.i_ack !== 1'b1) flag("i_ack_timeout");
            bus.i_req = 1'b0;
            if (k < n - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Data requester: same protocol, using whatever d_we/d_size/d_signed/d_wdata are set
    task automatic run_d(input logic [31:0] addr0, input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            bus.d_addr = addr0 + 32'(4 * k);
            bus.d_req  = 1'b1;
            do begin
                @(posedge clk); #1;
                t++;
            end while (bus.d_ack !== 1'b1 && t < 40);
            if (bus.d_ack !== 1'b1) flag("d_ack_timeout");
            bus.d_req = 1'b0;
            if (k < n - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] rd, input int waits);
        logic [31:0] wa;
        @(posedge clk); #1;
        slave_rdata = rd;
        wcnt = waits;
        wa = {addr[31:2], 2'b00};
        if (addr[1:0] != 2'b00) begin
            iq.push_back('{32'd0, 1'b1, cyc + 1});
        end else begin
            bq.push_back('{wa, 1'b0, 4'hF, 32'd0, cyc + 1});
            iq.push_back('{rd, 1'b0, cyc + 2 + waits});
        end
        run_i(addr, 1);
    endtask

    task automatic data(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                        input int waits, input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic exp_err);
        logic [31:0] wa;
        @(posedge clk); #1;
        slave_rdata  = rd;
        wcnt         = waits;
        bus.d_we     = we;
        bus.d_size   = size;
        bus.d_signed = sgn;
        bus.d_wdata  = wdata;
        wa = {addr[31:2], 2'b00};
        if (exp_err) begin
            dq.push_back('{32'd0, 1'b1, cyc + 1});
        end else begin
            bq.push_back('{wa, we, exp_be, exp_wdata, cyc + 1});
            dq.push_back('{exp_rdata, 1'b0, cyc + 2 + waits});
        end
        run_d(addr, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst          = 1'b1;
        bus.i_req    = 1'b0;
        bus.i_addr   = 32'd0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_size   = 2'd0;
        bus.d_signed = 1'b0;
        bus.d_addr   = 32'd0;
        bus.d_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ack", 32'(bus.i_ack), 32'd0);
        chk("rst_i_err", 32'(bus.i_err), 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'd0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
        chk("rst_d_err", 32'(bus.d_err), 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_address", bus.address, 32'd0);
        chk("rst_read", 32'(bus.read), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_writedata", bus.writedata, 32'd0);
        chk("rst_byteenable", 32'(bus.byteenable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // reset-vector fetch, zero wait
        fetch(32'hBFC00000, 32'h24020005, 0);

        // continuous contention after an instruction grant: D,I,D,I
        @(posedge clk); #1;
        slave_rdata  = 32'h11223344;
        wcnt         = 0;
        bus.d_we     = 1'b0;
        bus.d_size   = 2'd2;
        bus.d_signed = 1'b0;
        bus.d_wdata  = 32'd0;
        c0 = cyc;
        bq.push_back('{32'h00002000, 1'b0, 4'hF, 32'd0, c0 + 1});
        bq.push_back('{32'h00400000, 1'b0, 4'hF, 32'd0, c0 + 3});
        bq.push_back('{32'h00002004, 1'b0, 4'hF, 32'd0, c0 + 5});
        bq.push_back('{32'h00400004, 1'b0, 4'hF, 32'd0, c0 + 7});
        dq.push_back('{32'h11223344, 1'b0, c0 + 2});
        dq.push_back('{32'h11223344, 1'b0, c0 + 6});
        iq.push_back('{32'h11223344, 1'b0, c0 + 4});
        iq.push_back('{32'h11223344, 1'b0, c0 + 8});
        fork
            run_d(32'h00002000, 2);
            run_i(32'h00400000, 2);
        join

        //   we    size  sgn   addr           wdata          readdata       w  rdata          be       wdata          err
        data(1'b0, 2'd0, 1'b1, 32'h00001003, 32'd0,        32'h80FF1234, 0, 32'hFFFFFF80, 4'b1000, 32'd0,        1'b0);
        data(1'b0, 2'd0, 1'b0, 32'h00001003, 32'd0,        32'h80FF1234, 0, 32'h00000080, 4'b1000, 32'd0,        1'b0);
        data(1'b0, 2'd0, 1'b1, 32'h00001001, 32'd0,        32'h80FF1234, 0, 32'h00000012, 4'b0010, 32'd0,        1'b0);
        data(1'b1, 2'd1, 1'b0, 32'h00001002, 32'h0000ABCD, 32'd0,        3, 32'd0,        4'b1100, 32'hABCDABCD, 1'b0);
        data(1'b0, 2'd1, 1'b1, 32'h00002002, 32'd0,        32'h80017FFF, 0, 32'hFFFF8001, 4'b1100, 32'd0,        1'b0);
        data(1'b0, 2'd1, 1'b0, 32'h00002002, 32'd0,        32'h80017FFF, 0, 32'h00008001, 4'b1100, 32'd0,        1'b0);
        data(1'b0, 2'd1, 1'b1, 32'h00002000, 32'd0,        32'h80017FFF, 1, 32'h00007FFF, 4'b0011, 32'd0,        1'b0);
        data(1'b1, 2'd0, 1'b0, 32'h00002001, 32'hFFFFFF5A, 32'd0,        0, 32'd0,        4'b0010, 32'h5A5A5A5A, 1'b0);
        data(1'b1, 2'd2, 1'b0, 32'h00003000, 32'hDEADBEEF, 32'd0,        1, 32'd0,        4'b1111, 32'hDEADBEEF, 1'b0);
        data(1'b0, 2'd3, 1'b0, 32'h00003004, 32'd0,        32'h12345678, 0, 32'h12345678, 4'b1111, 32'd0,        1'b0);
        data(1'b0, 2'd1, 1'b0, 32'h00001003, 32'd0,        32'd0,        0, 32'd0,        4'b0000, 32'd0,        1'b1);
        data(1'b0, 2'd2, 1'b0, 32'h00001001, 32'd0,        32'd0,        0, 32'd0,        4'b0000, 32'd0,        1'b1);
        fetch(32'h00000400, 32'hA5A5F00F, 0);
        fetch(32'h00000102, 32'd0, 0);
        fetch(32'h00000404, 32'h0BADCAFE, 2);

        // reset while a data transfer is stalled by waitrequest
        @(posedge clk); #1;
        wcnt         = 10;
        slave_rdata  = 32'd0;
        bus.d_we     = 1'b1;
        bus.d_size   = 2'd2;
        bus.d_signed = 1'b0;
        bus.d_wdata  = 32'hCAFEF00D;
        bus.d_addr   = 32'h00003000;
        bq.push_back('{32'h00003000, 1'b1, 4'hF, 32'hCAFEF00D, cyc + 1});
        bus.d_req = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst       = 1'b1;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_read", 32'(bus.read), 32'd0);
        chk("midrst_write", 32'(bus.write), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_d_ack", 32'(bus.d_ack), 32'd0);
        rst = 1'b0;
        bq.delete();
        wcnt = 0;
        repeat (4) @(posedge clk);
        #1;

        // recovery after reset
        fetch(32'hBFC00004, 32'h00000000, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("leftover_expectations", 32'(iq.size() + dq.size() + bq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
